// File: rtl/wu_sched.sv
// Weight-update scheduler: walks NUM_GATES weight banks row by row with a drain
// pause after each row, and replays every read as a write-back WB_LAT steps later.
//
// state   | meaning
// IDLE    | waiting for start
// RUN     | one read per non-stalled cycle along the current row
// PAUSE   | PAUSE_LEN idle cycles after a row; picks next row/gate or drain
// DRAIN   | WB_LAT cycles flushing outstanding write-backs
// DONE    | one-cycle done pulse
module wu_sched #(
  parameter int ADDR_WIDTH = 12,
  parameter int ROW_LEN    = 53,
  parameter int NUM_ROWS   = 53,
  parameter int PAUSE_LEN  = 2,
  parameter int NUM_GATES  = 4,
  parameter int WB_LAT     = 3,
  parameter int GATE_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stall,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [GATE_WIDTH-1:0] rd_gate,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [GATE_WIDTH-1:0] wr_gate
);

  localparam int CW   = $clog2(ROW_LEN + 1);
  localparam int RW   = $clog2(NUM_ROWS + 1);
  localparam int TMAX = (PAUSE_LEN > WB_LAT) ? PAUSE_LEN : WB_LAT;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0]         COL_LAST   = CW'(ROW_LEN - 1);
  localparam logic [RW-1:0]         ROW_LAST   = RW'(NUM_ROWS - 1);
  localparam logic [GATE_WIDTH-1:0] GATE_LAST  = GATE_WIDTH'(NUM_GATES - 1);
  localparam logic [TW-1:0]         PAUSE_LOAD = TW'(PAUSE_LEN - 1);
  localparam logic [TW-1:0]         DRAIN_LOAD = TW'(WB_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_PAUSE = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         col, col_nxt;
  logic [RW-1:0]         row, row_nxt;
  logic [GATE_WIDTH-1:0] gate, gate_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [TW-1:0]         tmr, tmr_nxt;

  logic                  rd_en_nxt;
  logic [ADDR_WIDTH-1:0] rd_addr_nxt;
  logic [GATE_WIDTH-1:0] rd_gate_nxt;
  logic                  busy_nxt;
  logic                  done_nxt;
  logic                  adv;

  logic                  dl_en   [WB_LAT];
  logic [ADDR_WIDTH-1:0] dl_addr [WB_LAT];
  logic [GATE_WIDTH-1:0] dl_gate [WB_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    col_nxt     = col;
    row_nxt     = row;
    gate_nxt    = gate;
    addr_nxt    = addr;
    tmr_nxt     = tmr;
    rd_en_nxt   = 1'b0;
    rd_addr_nxt = rd_addr;
    rd_gate_nxt = rd_gate;
    busy_nxt    = (state != S_IDLE);
    done_nxt    = 1'b0;
    adv         = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
          col_nxt   = '0;
          row_nxt   = '0;
          gate_nxt  = '0;
          addr_nxt  = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          adv         = 1'b1;
          rd_en_nxt   = 1'b1;
          rd_addr_nxt = addr;
          rd_gate_nxt = gate;
          if (col == COL_LAST) begin
            col_nxt   = '0;
            tmr_nxt   = PAUSE_LOAD;
            state_nxt = S_PAUSE;
          end else begin
            col_nxt  = col + 1'b1;
            addr_nxt = addr + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        if (!stall) begin
          adv = 1'b1;
          if (tmr != '0) begin
            tmr_nxt = tmr - 1'b1;
          end else if (row != ROW_LAST) begin
            // addr still points at the last column read, so +1 starts the next row
            row_nxt   = row + 1'b1;
            addr_nxt  = addr + 1'b1;
            state_nxt = S_RUN;
          end else if (gate != GATE_LAST) begin
            gate_nxt  = gate + 1'b1;
            row_nxt   = '0;
            addr_nxt  = '0;
            state_nxt = S_RUN;
          end else begin
            tmr_nxt   = DRAIN_LOAD;
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!stall) begin
          adv = 1'b1;
          if (tmr == '0) state_nxt = S_DONE;
          else           tmr_nxt   = tmr - 1'b1;
        end
      end
      S_DONE: begin
        done_nxt  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col     <= '0;
      row     <= '0;
      gate    <= '0;
      addr    <= '0;
      tmr     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rd_gate <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_gate <= '0;
      for (int i = 0; i < WB_LAT; i++) begin
        dl_en[i]   <= 1'b0;
        dl_addr[i] <= '0;
        dl_gate[i] <= '0;
      end
    end else begin
      col     <= col_nxt;
      row     <= row_nxt;
      gate    <= gate_nxt;
      addr    <= addr_nxt;
      tmr     <= tmr_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      rd_en   <= rd_en_nxt;
      rd_addr <= rd_addr_nxt;
      rd_gate <= rd_gate_nxt;
      // delay line only moves on non-stalled sequencing cycles
      if (adv) begin
        wr_en   <= dl_en[WB_LAT-1];
        wr_addr <= dl_addr[WB_LAT-1];
        wr_gate <= dl_gate[WB_LAT-1];
        for (int i = WB_LAT - 1; i > 0; i--) begin
          dl_en[i]   <= dl_en[i-1];
          dl_addr[i] <= dl_addr[i-1];
          dl_gate[i] <= dl_gate[i-1];
        end
        dl_en[0]   <= rd_en_nxt;
        dl_addr[0] <= rd_addr_nxt;
        dl_gate[0] <= rd_gate_nxt;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wu_sched.sv
// Bench for wu_sched: directed vector table, hand-written corner sequences and
// randomized stall runs against a slot-list reference model.
module tb_wu_sched;

  localparam int AW    = 12;
  localparam int RL    = 4;
  localparam int NR    = 3;
  localparam int PL    = 2;
  localparam int NG    = 2;
  localparam int WL    = 3;
  localparam int GW    = 2;
  localparam int WORDS = RL * NR;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          stall = 1'b0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [GW-1:0] rd_gate, wr_gate;

  always #5 clk = ~clk;

  wu_sched #(
    .ADDR_WIDTH(AW), .ROW_LEN(RL), .NUM_ROWS(NR), .PAUSE_LEN(PL),
    .NUM_GATES(NG), .WB_LAT(WL), .GATE_WIDTH(GW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_gate(rd_gate),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_gate(wr_gate)
  );

  int n_pass = 0;
  int n_total = 0;
  int gcyc = 0;

  logic start_pat [0:511];
  logic stall_pat [0:511];
  logic rec_en    [0:511];
  int   rec_addr  [0:511];
  int   rec_gate  [0:511];
  logic rec_busy  [0:511];
  logic rec_done  [0:511];
  logic rec_wen   [0:511];
  int   rec_waddr [0:511];

  int done_edge;
  int run_start_abs;
  int done_abs;
  int model_last_addr;
  int model_last_gate;

  typedef struct {
    logic en;
    int   addr;
    int   gate;
  } slot_t;

  typedef struct {
    int   cyc;
    logic en;
    int   addr;
    int   gate;
    logic done;
    logic busy;
    logic wen;
    int   waddr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @abs cycle %0d: got %0d, expected %0d", name, gcyc, act, exp);
  endtask

  task automatic tick(input logic s_start, input logic s_stall);
    @(negedge clk);
    start = s_start;
    stall = s_stall;
    @(posedge clk);
    #1;
    gcyc++;
  endtask

  task automatic record(input int e);
    rec_en[e]    = rd_en;
    rec_addr[e]  = int'(rd_addr);
    rec_gate[e]  = int'(rd_gate);
    rec_busy[e]  = busy;
    rec_done[e]  = done;
    rec_wen[e]   = wr_en;
    rec_waddr[e] = int'(wr_addr);
  endtask

  task automatic clear_pats();
    for (int i = 0; i < 512; i++) begin
      start_pat[i] = 1'b0;
      stall_pat[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    @(negedge clk);
    rst = 1'b1;
    model_last_addr = 0;
    model_last_gate = 0;
  endtask

  // Reference: the run is a flat list of slots (reads then pause per row, then
  // drain), one slot per non-stalled cycle; writes replay slot k-WL.
  task automatic do_run();
    slot_t slots[$];
    slot_t s;
    int k;
    slots = {};
    for (int g = 0; g < NG; g++)
      for (int r = 0; r < NR; r++) begin
        for (int c = 0; c < RL; c++) begin
          s.en = 1'b1; s.addr = r * RL + c; s.gate = g;
          slots.push_back(s);
        end
        for (int p = 0; p < PL; p++) begin
          s.en = 1'b0; s.addr = 0; s.gate = 0;
          slots.push_back(s);
        end
      end
    for (int d = 0; d < WL; d++) begin
      s.en = 1'b0; s.addr = 0; s.gate = 0;
      slots.push_back(s);
    end

    done_edge = -1;
    tick(start_pat[0], stall_pat[0]);
    run_start_abs = gcyc;
    record(0);
    chk("idle_busy", busy, 0);
    chk("idle_rd_en", rd_en, 0);
    chk("idle_wr_en", wr_en, 0);
    chk("idle_done", done, 0);
    k = 0;
    for (int e = 1; e < 400 && done_edge < 0; e++) begin
      tick(start_pat[e], stall_pat[e]);
      record(e);
      if (k == slots.size()) begin
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_rd_en", rd_en, 0);
        chk("done_wr_en", wr_en, 0);
        done_edge = e;
        done_abs = gcyc;
      end else begin
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        if (stall_pat[e]) begin
          chk("stall_rd_en", rd_en, 0);
          chk("stall_wr_en", wr_en, 0);
          chk("stall_rd_addr_hold", rd_addr, model_last_addr);
          chk("stall_rd_gate_hold", rd_gate, model_last_gate);
        end else begin
          chk("rd_en", rd_en, slots[k].en);
          if (slots[k].en) begin
            chk("rd_addr", rd_addr, slots[k].addr);
            chk("rd_gate", rd_gate, slots[k].gate);
            model_last_addr = slots[k].addr;
            model_last_gate = slots[k].gate;
          end
          if (k >= WL) begin
            chk("wr_en", wr_en, slots[k-WL].en);
            if (slots[k-WL].en) begin
              chk("wr_addr", wr_addr, slots[k-WL].addr);
              chk("wr_gate", wr_gate, slots[k-WL].gate);
            end
          end else begin
            chk("wr_en_early", wr_en, 0);
          end
          k++;
        end
        if (wr_en) chk("wr_addr_range", wr_addr < AW'(WORDS), 1);
      end
    end
    if (done_edge < 0) chk("done_timeout", 0, 1);
  endtask

  vec_t tbl [10];
  int   n_rd, n_wr;

  initial begin
    tbl[0] = '{cyc: 0,  en: 0, addr: 0,  gate: 0, done: 0, busy: 0, wen: 0, waddr: 0};
    tbl[1] = '{cyc: 1,  en: 1, addr: 0,  gate: 0, done: 0, busy: 1, wen: 0, waddr: 0};
    tbl[2] = '{cyc: 4,  en: 1, addr: 3,  gate: 0, done: 0, busy: 1, wen: 1, waddr: 0};
    tbl[3] = '{cyc: 5,  en: 0, addr: 0,  gate: 0, done: 0, busy: 1, wen: 1, waddr: 1};
    tbl[4] = '{cyc: 6,  en: 0, addr: 0,  gate: 0, done: 0, busy: 1, wen: 1, waddr: 2};
    tbl[5] = '{cyc: 7,  en: 1, addr: 4,  gate: 0, done: 0, busy: 1, wen: 1, waddr: 3};
    tbl[6] = '{cyc: 18, en: 0, addr: 0,  gate: 0, done: 0, busy: 1, wen: 1, waddr: 10};
    tbl[7] = '{cyc: 19, en: 1, addr: 0,  gate: 1, done: 0, busy: 1, wen: 1, waddr: 11};
    tbl[8] = '{cyc: 34, en: 1, addr: 11, gate: 1, done: 0, busy: 1, wen: 1, waddr: 8};
    tbl[9] = '{cyc: 40, en: 0, addr: 0,  gate: 0, done: 1, busy: 1, wen: 0, waddr: 0};

    do_reset();

    // full unstalled run
    clear_pats();
    start_pat[0] = 1'b1;
    do_run();
    chk("full_done_cycle", done_edge, 40);
    for (int i = 0; i < 10; i++) begin
      chk("tbl_rd_en", rec_en[tbl[i].cyc], tbl[i].en);
      if (tbl[i].en) begin
        chk("tbl_rd_addr", rec_addr[tbl[i].cyc], tbl[i].addr);
        chk("tbl_rd_gate", rec_gate[tbl[i].cyc], tbl[i].gate);
      end
      chk("tbl_done", rec_done[tbl[i].cyc], tbl[i].done);
      chk("tbl_busy", rec_busy[tbl[i].cyc], tbl[i].busy);
      chk("tbl_wr_en", rec_wen[tbl[i].cyc], tbl[i].wen);
      if (tbl[i].wen) chk("tbl_wr_addr", rec_waddr[tbl[i].cyc], tbl[i].waddr);
    end
    n_rd = 0;
    n_wr = 0;
    for (int e = 0; e <= 40; e++) begin
      if (rec_en[e])  n_rd++;
      if (rec_wen[e]) n_wr++;
    end
    chk("full_read_count", n_rd, 24);
    chk("full_write_count", n_wr, 24);

    // stall in cycles 3-5
    clear_pats();
    start_pat[0] = 1'b1;
    for (int e = 3; e <= 5; e++) stall_pat[e] = 1'b1;
    do_run();
    chk("stall_addr_c6", rec_addr[6], 2);
    chk("stall_en_c6", rec_en[6], 1);
    chk("stall_done_cycle", done_edge, 43);

    // start while busy, then back-to-back start in the post-done IDLE cycle
    clear_pats();
    start_pat[0]  = 1'b1;
    start_pat[10] = 1'b1;
    do_run();
    chk("busy_start_done_cycle", done_edge, 40);
    n_rd = run_start_abs;
    clear_pats();
    start_pat[0] = 1'b1;
    do_run();
    chk("second_run_done_cycle", done_abs - n_rd, 81);

    // start with stall held
    clear_pats();
    start_pat[0] = 1'b1;
    for (int e = 0; e <= 2; e++) stall_pat[e] = 1'b1;
    do_run();
    chk("ss_busy_c1", rec_busy[1], 1);
    chk("ss_rd_en_c2", rec_en[2], 0);
    chk("ss_rd_en_c3", rec_en[3], 1);
    chk("ss_rd_addr_c3", rec_addr[3], 0);
    chk("ss_done_cycle", done_edge, 42);

    // reset mid-run
    tick(1'b1, 1'b0);
    for (int e = 1; e <= 15; e++) begin
      tick(1'b0, 1'b0);
      chk("prereset_done", done, 0);
    end
    #2;
    rst = 1'b0;
    #1;
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_rd_en", rd_en, 0);
    chk("mid_reset_rd_addr", rd_addr, 0);
    chk("mid_reset_rd_gate", rd_gate, 0);
    chk("mid_reset_wr_en", wr_en, 0);
    chk("mid_reset_wr_addr", wr_addr, 0);
    model_last_addr = 0;
    model_last_gate = 0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk);
      #1;
      chk("in_reset_done", done, 0);
      chk("in_reset_wr_en", wr_en, 0);
    end
    @(negedge clk);
    rst = 1'b1;
    clear_pats();
    start_pat[0] = 1'b1;
    do_run();
    chk("post_reset_addr_c1", rec_addr[1], 0);
    chk("post_reset_gate_c1", rec_gate[1], 0);

    // randomized stall and spurious start
    for (int r = 0; r < 6; r++) begin
      clear_pats();
      start_pat[0] = 1'b1;
      for (int e = 0; e < 400; e++) begin
        stall_pat[e] = ($urandom_range(0, 3) == 0);
        if (e > 0) start_pat[e] = ($urandom_range(0, 4) == 0);
      end
      do_run();
    end

    tick(1'b0, 1'b0);
    chk("final_busy", busy, 0);
    chk("final_done", done, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wu_sched.md
# wu_sched

Weight-update scheduler for the LSTM backprop datapath. Sequences one shared weight-memory address stream across `NUM_GATES` gate weight banks. Each bank is walked row by row with a fixed pause inserted after every row so the update MAC pipeline can drain. The block also produces the delayed write-back strobes and addresses, and handshakes with the top-level controller through start/busy/done and with the datapath through a global stall.

## Interface
- `ADDR_WIDTH`, 12: width of read/write addresses; `ROW_LEN*NUM_ROWS-1` must fit.
- `ROW_LEN`, 53: reads per row (columns).
- `NUM_ROWS`, 53: rows per gate bank (53*53 = 2809 words).
- `PAUSE_LEN`, 2: idle cycles inserted after every row, ≥1.
- `NUM_GATES`, 4: gate banks walked in order 0..NUM_GATES-1, ≥1.
- `WB_LAT`, 3: read-to-write-back latency in non-stalled cycles, ≥1.
- `GATE_WIDTH`, 2: width of gate selects, ≥ clog2(NUM_GATES).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `start` in 1: start request, sampled in IDLE only.
- `stall` in 1: datapath not ready; freezes all sequencing.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at completion.
- `rd_en` out 1: weight/gradient read strobe.
- `rd_addr` out ADDR_WIDTH: read address within bank.
- `rd_gate` out GATE_WIDTH: bank select for the read.
- `wr_en` out 1: write-back strobe for the updated weight.
- `wr_addr` out ADDR_WIDTH: write-back address.
- `wr_gate` out GATE_WIDTH: bank select for the write.

## Operation
- All outputs are registered. Reset value of every output, counter, state and delay-line stage is 0; the FSM resets to IDLE.
- Reset asserted mid-operation aborts immediately. No done pulse is produced, and pending write-backs are discarded.
- FSM states: IDLE, RUN, PAUSE, DRAIN, DONE.
- IDLE: `start`=1 → RUN, clearing col, row, gate and address counters. `start` is accepted even if `stall`=1. `start` in any other state is ignored.
- RUN, non-stalled cycle: `rd_en`=1, `rd_addr`=row*ROW_LEN+col (kept as a linear counter, not a multiplier), `rd_gate`=gate.
  - The col increments each read.
  - After the read with col=ROW_LEN-1 → PAUSE, with col cleared.
- PAUSE: `rd_en`=0 for PAUSE_LEN non-stalled cycles. The pause also follows the last row of each gate. At pause end:
  - If row<NUM_ROWS-1: row+1, address continues linearly → RUN.
  - Else if gate<NUM_GATES-1: gate+1, row and address cleared → RUN.
  - Else → DRAIN.
- DRAIN: WB_LAT non-stalled cycles, `rd_en`=0, then → DONE.
- DONE: one cycle, `done`=1, `busy`=1 → IDLE. The DONE state ignores `stall`.
- Write-back delay line: WB_LAT stages of {en, addr, gate} fed from the read outputs. `wr_*` equal the values from WB_LAT non-stalled cycles earlier.
- `stall`=1 in RUN/PAUSE/DRAIN:
  - Counters, FSM and delay line hold.
  - `rd_en` and `wr_en` are forced to 0 that cycle.
  - `rd_addr`, `rd_gate`, `wr_addr` and `wr_gate` hold their values.
- Address arithmetic is unsigned and wraps to 0 only via the explicit clears above. No address ≥ ROW_LEN*NUM_ROWS is ever issued.

## Timing
- `start` sampled at edge 0 gives the first `rd_en`=1 with `rd_addr`=0 in cycle 1, unless stalled.
- Per gate: NUM_ROWS*(ROW_LEN+PAUSE_LEN) non-stalled cycles.
- Unstalled total from start to the `done` cycle: 1 + NUM_GATES*NUM_ROWS*(ROW_LEN+PAUSE_LEN) + WB_LAT cycles.
- Each stalled cycle in RUN/PAUSE/DRAIN adds exactly one cycle to that total.
- `wr_en` for the read issued in cycle t appears in cycle t+WB_LAT, given no stalls. The last `wr_en` always precedes `done`.
- `busy` rises the cycle after `start` is sampled and falls the cycle after `done`. A new `start` is accepted in that IDLE cycle.

## Test plan
Bench parameters: ROW_LEN=4, NUM_ROWS=3, PAUSE_LEN=2, NUM_GATES=2, WB_LAT=3.

- **Full unstalled run:** start at cycle 0.
  - `rd_en` high in cycles 1-4 with addr 0-3, low in cycles 5-6, addr 4 in cycle 7.
  - Gate 1 addr 0 appears in cycle 19; last read (gate 1, addr 11) in cycle 34.
  - `done` in cycle 40; 24 reads and 24 writes total.
- **Write-back:** for every read at cycle t, `wr_en`/`wr_addr`/`wr_gate` match it at t+3. `wr_en` is never high for an address outside 0-11.
- **Stall:** `stall`=1 for cycles 3-5.
  - `rd_en`=0 and `wr_en`=0 in cycles 3-5.
  - `rd_addr` in cycle 6 = 2 (the value due in cycle 3).
  - `done` arrives in cycle 43.
- **Start while busy:** pulse `start` at cycles 0 and 10 → a single run with `done` in cycle 40. Start at cycle 41 → a second run with `done` in cycle 81.
- **Reset mid-run:** `rst`=0 at cycle 15 → all outputs 0 and `busy`=0 immediately, no `done`. Start after release gives `rd_addr`=0, `rd_gate`=0.
- **Start with stall:** `start` with `stall`=1 held 2 cycles → `busy`=1 at cycle 1, first `rd_en` at cycle 3.
